// File: rtl/pht_port_scheduler_if.sv
// Bundle of the prediction-request, feedback and PHT RAM signals around the
// PHT port scheduler. The scheduler is the slave; the branch controller/RAM side is the master.
interface pht_port_scheduler_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
);
    logic                   init_done;
    logic                   req_valid;
    logic [ADDR_WIDTH-1:0]  req_pc;
    logic                   req_ready;
    logic                   pred_valid;
    logic                   pred_taken;
    logic                   fb_valid;
    logic [ADDR_WIDTH-1:0]  fb_pc;
    logic                   fb_taken;
    logic                   fb_ready;
    logic                   pht_en;
    logic                   pht_we;
    logic [INDEX_WIDTH-1:0] pht_addr;
    logic [1:0]             pht_wdata;
    logic [1:0]             pht_rdata;

    modport slave (
        output init_done, req_ready, pred_valid, pred_taken, fb_ready,
               pht_en, pht_we, pht_addr, pht_wdata,
        input  req_valid, req_pc, fb_valid, fb_pc, fb_taken, pht_rdata
    );

    modport master (
        input  init_done, req_ready, pred_valid, pred_taken, fb_ready,
               pht_en, pht_we, pht_addr, pht_wdata,
        output req_valid, req_pc, fb_valid, fb_pc, fb_taken, pht_rdata
    );
endinterface

// File: rtl/pht_port_scheduler.sv
// Arbitrates the single PHT port between prediction reads and queued feedback
// read-modify-write updates, and fills the table with weakly-taken after reset.
module pht_port_scheduler #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 6,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 rst,
    pht_port_scheduler_if.slave bus
);
    localparam int QPTR_W   = $clog2(QDEPTH);
    localparam int QCNT_W   = QPTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
    localparam logic [QCNT_W-1:0]      QCNT_FULL  = QCNT_W'(QDEPTH);
    localparam logic [STARVE_W-1:0]    STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // The read half of an update is issued in the arbitration cycle itself,
    // so an update holds the port for exactly two cycles (read, then write).
    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_UPD_WR
    } state_t;

    state_t                 state_reg, state_next;
    logic [INDEX_WIDTH-1:0] init_ptr_reg, init_ptr_next;
    logic                   init_arm_reg, init_arm_next;
    logic                   init_done_reg, init_done_next;
    logic [STARVE_W-1:0]    starve_reg, starve_next;

    logic [INDEX_WIDTH-1:0] q_index_reg [QDEPTH];
    logic                   q_taken_reg [QDEPTH];
    logic [QPTR_W-1:0]      wr_ptr_reg;
    logic [QPTR_W-1:0]      rd_ptr_reg;
    logic [QCNT_W-1:0]      count_reg;

    logic [INDEX_WIDTH-1:0] upd_index_reg;
    logic                   upd_taken_reg;
    logic                   pred_valid_reg;

    logic                   q_empty;
    logic                   q_full;
    logic                   push;
    logic                   pop;
    logic                   grant;
    logic [1:0]             upd_wdata;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [INDEX_WIDTH-1:0] fb_index;
    logic                   unused_pc_bits;

    assign req_index = bus.req_pc[INDEX_WIDTH+1:2];
    assign fb_index  = bus.fb_pc[INDEX_WIDTH+1:2];
    assign unused_pc_bits = ^{bus.req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], bus.req_pc[1:0],
                              bus.fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], bus.fb_pc[1:0]};

    assign q_empty = (count_reg == '0);
    assign q_full  = (count_reg == QCNT_FULL);

    // Full queue refuses feedback even in a cycle that pops.
    assign bus.fb_ready = init_done_reg && !q_full;
    assign push         = bus.fb_valid && bus.fb_ready;

    assign bus.init_done  = init_done_reg;
    assign bus.req_ready  = grant;
    assign bus.pred_valid = pred_valid_reg;
    assign bus.pred_taken = pred_valid_reg && bus.pht_rdata[1];

    // 2-bit saturating counter step applied to the value read back for the update.
    always_comb begin
        upd_wdata = bus.pht_rdata;
        if (upd_taken_reg) begin
            if (bus.pht_rdata != 2'b11) begin
                upd_wdata = bus.pht_rdata + 2'b01;
            end
        end else begin
            if (bus.pht_rdata != 2'b00) begin
                upd_wdata = bus.pht_rdata - 2'b01;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_ptr_next  = init_ptr_reg;
        init_arm_next  = init_arm_reg;
        init_done_next = init_done_reg;
        starve_next    = starve_reg;
        pop            = 1'b0;
        grant          = 1'b0;
        bus.pht_en     = 1'b0;
        bus.pht_we     = 1'b0;
        bus.pht_addr   = '0;
        bus.pht_wdata  = 2'b00;

        case (state_reg)
            S_INIT: begin
                // First cycle after reset stays quiet so a dropped update never
                // leaves a write on the port behind it.
                if (!init_arm_reg) begin
                    init_arm_next = 1'b1;
                end else begin
                    bus.pht_en    = 1'b1;
                    bus.pht_we    = 1'b1;
                    bus.pht_addr  = init_ptr_reg;
                    bus.pht_wdata = 2'b10;
                    init_ptr_next = init_ptr_reg + 1'b1;
                    if (init_ptr_reg == LAST_INDEX) begin
                        state_next     = S_IDLE;
                        init_done_next = 1'b1;
                    end
                end
            end

            S_IDLE: begin
                if (!q_empty && (q_full || (starve_reg >= STARVE_MAX) || !bus.req_valid)) begin
                    pop          = 1'b1;
                    bus.pht_en   = 1'b1;
                    bus.pht_addr = q_index_reg[rd_ptr_reg];
                    starve_next  = '0;
                    state_next   = S_UPD_WR;
                end else if (bus.req_valid) begin
                    grant        = 1'b1;
                    bus.pht_en   = 1'b1;
                    bus.pht_addr = req_index;
                    if (!q_empty && (starve_reg < STARVE_MAX)) begin
                        starve_next = starve_reg + 1'b1;
                    end
                end
            end

            S_UPD_WR: begin
                bus.pht_en    = 1'b1;
                bus.pht_we    = 1'b1;
                bus.pht_addr  = upd_index_reg;
                bus.pht_wdata = upd_wdata;
                state_next    = S_IDLE;
            end

            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_INIT;
            init_ptr_reg   <= '0;
            init_arm_reg   <= 1'b0;
            init_done_reg  <= 1'b0;
            starve_reg     <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            upd_index_reg  <= '0;
            upd_taken_reg  <= 1'b0;
            pred_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            init_ptr_reg   <= init_ptr_next;
            init_arm_reg   <= init_arm_next;
            init_done_reg  <= init_done_next;
            starve_reg     <= starve_next;
            pred_valid_reg <= grant;
            count_reg      <= count_reg + QCNT_W'(push) - QCNT_W'(pop);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                upd_index_reg <= q_index_reg[rd_ptr_reg];
                upd_taken_reg <= q_taken_reg[rd_ptr_reg];
            end
        end
    end

    // Queue payload needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            q_index_reg[wr_ptr_reg] <= fb_index;
            q_taken_reg[wr_ptr_reg] <= bus.fb_taken;
        end
    end
endmodule

// File: tb/tb_pht_port_scheduler.sv
// Directed bench for pht_port_scheduler with a behavioural synchronous-read PHT RAM.
module tb_pht_port_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] mem [64];

    always #5 clk = ~clk;

    pht_port_scheduler_if #(.ADDR_WIDTH(32), .INDEX_WIDTH(6)) bus ();

    pht_port_scheduler #(
        .ADDR_WIDTH(32), .INDEX_WIDTH(6), .QDEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous-read single-port RAM model
    always @(posedge clk) begin
        if (bus.pht_en) begin
            if (bus.pht_we) mem[bus.pht_addr] <= bus.pht_wdata;
            else            bus.pht_rdata <= mem[bus.pht_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp_acc;
        int bad_entries;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h0;
        @(negedge clk);
        checks++;
        if ({bus.pht_en, bus.init_done, bus.req_ready, bus.fb_ready, bus.pred_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got en,done,rr,fr,pv=%b required 00000",
                     {bus.pht_en, bus.init_done, bus.req_ready, bus.fb_ready, bus.pred_valid});
        end
        step();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            exp_acc = {1'b1, 1'b1, 6'(i), 2'b10};
            checks++;
            if ({bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== exp_acc ||
                bus.req_ready !== 1'b0 || bus.fb_ready !== 1'b0 || bus.init_done !== 1'b0) begin
                failures++;
                $display("FAIL init_write[%0d]: got acc=%h rr=%b fr=%b done=%b required acc=%h rr=0 fr=0 done=0",
                         i, {bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata},
                         bus.req_ready, bus.fb_ready, bus.init_done, exp_acc);
            end
            step();
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.init_done, bus.fb_ready, bus.pht_en} !== 3'b110) begin
            failures++;
            $display("FAIL init_done: got done,fr,en=%b required 110",
                     {bus.init_done, bus.fb_ready, bus.pht_en});
        end
        bad_entries = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 2'b10) bad_entries++;
        checks++;
        if (bad_entries != 0) begin
            failures++;
            $display("FAIL init_table: got %0d entries not 2 required 0", bad_entries);
        end
        step();
        $display("test_reset: 64 init writes observed");
    endtask

    task automatic test_predict(input logic [31:0] pc, input logic [5:0] idx, input logic exp_taken,
                                input string tag);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.pht_en, bus.pht_we, bus.pht_addr} !== {3'b110, idx}) begin
            failures++;
            $display("FAIL %s_grant: got rr,en,we,addr=%b required %b", tag,
                     {bus.req_ready, bus.pht_en, bus.pht_we, bus.pht_addr}, {3'b110, idx});
        end
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pred_valid, bus.pred_taken} !== {1'b1, exp_taken}) begin
            failures++;
            $display("FAIL %s_pred: got pv,pt=%b required %b", tag,
                     {bus.pred_valid, bus.pred_taken}, {1'b1, exp_taken});
        end
        step();
        $display("%s: pc=%h predicted %0d", tag, pc, exp_taken);
    endtask

    task automatic test_update();
        logic       taken_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] wr_seq    [6] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        for (int k = 0; k < 6; k++) begin
            bus.fb_valid = 1'b1;
            bus.fb_pc    = 32'h10;
            bus.fb_taken = taken_seq[k];
            @(negedge clk);
            checks++;
            if (bus.fb_ready !== 1'b1) begin
                failures++;
                $display("FAIL upd%0d_fb_ready: got %b required 1", k, bus.fb_ready);
            end
            step();
            bus.fb_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.pht_en, bus.pht_we, bus.pht_addr} !== {2'b10, 6'd4}) begin
                failures++;
                $display("FAIL upd%0d_read: got en,we,addr=%b required %b", k,
                         {bus.pht_en, bus.pht_we, bus.pht_addr}, {2'b10, 6'd4});
            end
            step();
            @(negedge clk);
            checks++;
            if ({bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {2'b11, 6'd4, wr_seq[k]}) begin
                failures++;
                $display("FAIL upd%0d_write: got en,we,addr,wdata=%b required %b", k,
                         {bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata},
                         {2'b11, 6'd4, wr_seq[k]});
            end
            step();
            $display("test_update: fb taken=%0d wrote %0d", taken_seq[k], wr_seq[k]);
        end
        test_predict(32'h10, 6'd4, 1'b0, "pred_after_updates");
    endtask

    task automatic test_starvation();
        int grants = 0;
        bit stopped = 0;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h20;
        bus.fb_valid  = 1'b1;
        bus.fb_pc     = 32'h40;
        bus.fb_taken  = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.fb_ready} !== 2'b11) begin
            failures++;
            $display("FAIL starve_enqueue: got rr,fr=%b required 11", {bus.req_ready, bus.fb_ready});
        end
        step();
        bus.fb_valid = 1'b0;
        for (int c = 0; c < 20 && !stopped; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                grants++;
                step();
            end else begin
                stopped = 1;
            end
        end
        checks++;
        if (!stopped || grants != 8) begin
            failures++;
            $display("FAIL starve_grants: got %0d grants (stopped=%0d) required 8", grants, stopped);
        end
        checks++;
        if ({bus.req_ready, bus.pht_en, bus.pht_we, bus.pht_addr} !== {3'b010, 6'd16}) begin
            failures++;
            $display("FAIL starve_upd_read: got rr,en,we,addr=%b required %b",
                     {bus.req_ready, bus.pht_en, bus.pht_we, bus.pht_addr}, {3'b010, 6'd16});
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {2'b01, 6'd16, 2'd3}) begin
            failures++;
            $display("FAIL starve_upd_write: got rr,we,addr,wdata=%b required %b",
                     {bus.req_ready, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {2'b01, 6'd16, 2'd3});
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || dut.starve_reg !== '0) begin
            failures++;
            $display("FAIL starve_resume: got rr=%b starve=%0d required rr=1 starve=0",
                     bus.req_ready, dut.starve_reg);
        end
        step();
        bus.req_valid = 1'b0;
        step();
        $display("test_starvation: %0d grants before update", grants);
    endtask

    task automatic test_back_to_back();
        logic tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h20;
        for (int k = 0; k < 4; k++) begin
            bus.fb_valid = 1'b1;
            bus.fb_pc    = 32'h80 + 32'(4 * k);
            bus.fb_taken = tk[k];
            @(negedge clk);
            checks++;
            if ({bus.fb_ready, bus.req_ready} !== 2'b11) begin
                failures++;
                $display("FAIL b2b_push%0d: got fr,rr=%b required 11", k, {bus.fb_ready, bus.req_ready});
            end
            step();
        end
        bus.fb_pc    = 32'h90;
        bus.fb_taken = tk[4];
        @(negedge clk);
        checks++;
        if ({bus.fb_ready, bus.req_ready, bus.pht_en, bus.pht_we, bus.pht_addr} !== {4'b0010, 6'd32}) begin
            failures++;
            $display("FAIL b2b_full_pop: got fr,rr,en,we,addr=%b required %b",
                     {bus.fb_ready, bus.req_ready, bus.pht_en, bus.pht_we, bus.pht_addr}, {4'b0010, 6'd32});
        end
        step();
        bus.fb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.fb_ready, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {2'b11, 6'd32, 2'd3}) begin
            failures++;
            $display("FAIL b2b_after_pop: got fr,we,addr,wdata=%b required %b",
                     {bus.fb_ready, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {2'b11, 6'd32, 2'd3});
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_grant_resume: got rr=%b required 1", bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        repeat (8) step();
        checks++;
        if ({mem[33], mem[34], mem[35], mem[36]} !== {2'd1, 2'd3, 2'd1, 2'd2}) begin
            failures++;
            $display("FAIL b2b_drain: got mem33..36=%b required %b",
                     {mem[33], mem[34], mem[35], mem[36]}, {2'd1, 2'd3, 2'd1, 2'd2});
        end
        $display("test_back_to_back: 4 queued, 5th refused, drained");
    endtask

    task automatic test_reset_mid_update();
        bus.fb_valid = 1'b1;
        bus.fb_pc    = 32'hC0;
        bus.fb_taken = 1'b0;
        step();
        bus.fb_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.pht_en, bus.pht_we, bus.pht_addr} !== {2'b10, 6'd48}) begin
            failures++;
            $display("FAIL rstmid_read: got en,we,addr=%b required %b",
                     {bus.pht_en, bus.pht_we, bus.pht_addr}, {2'b10, 6'd48});
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pht_en, bus.pred_valid, bus.init_done, bus.fb_ready} !== 4'b0 || dut.count_reg !== '0) begin
            failures++;
            $display("FAIL rstmid_quiet: got en,pv,done,fr=%b qcount=%0d required 0000 qcount=0",
                     {bus.pht_en, bus.pred_valid, bus.init_done, bus.fb_ready}, dut.count_reg);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {2'b11, 6'(i), 2'b10}) begin
                failures++;
                $display("FAIL rstmid_init%0d: got %b required %b", i,
                         {bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {2'b11, 6'(i), 2'b10});
            end
            step();
        end
        $display("test_reset_mid_update: init restarted at 0");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 2'b01;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.fb_valid  = 1'b0;
        bus.fb_pc     = '0;
        bus.fb_taken  = 1'b0;
        bus.pht_rdata = 2'b00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_predict(32'h10, 6'd4, 1'b1, "pred_initial");
        test_update();
        test_starvation();
        test_back_to_back();
        test_reset_mid_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pht_port_scheduler.md
Name: pht_port_scheduler

Overview:
- Sequences a single-ported, synchronous-read pattern history table (PHT) of 2-bit saturating counters. The PHT is shared between decode-stage prediction reads and execute-stage feedback updates.
- Queues feedback, performs read-modify-write updates, and guarantees updates are not starved by back-to-back prediction requests.
- Initializes every PHT entry after reset. Sits between branch_controller's request/feedback paths and the PHT RAM.

Parameters:
- ADDR_WIDTH, 32, PC width.
- INDEX_WIDTH, 6, PHT index bits; table depth is 2^INDEX_WIDTH.
- QDEPTH, 4, feedback queue entries (power of 2, ≥2).
- STARVE_LIMIT, 8, maximum consecutive request grants while the queue is non-empty.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- init_done  out  1  high once PHT initialization is complete
- req_valid  in  1  prediction request
- req_pc  in  ADDR_WIDTH  branch PC
- req_ready  out  1  request granted this cycle
- pred_valid  out  1  prediction available (one cycle after grant)
- pred_taken  out  1  prediction (1 = TAKEN)
- fb_valid  in  1  resolved-branch feedback
- fb_pc  in  ADDR_WIDTH  resolved-branch PC
- fb_taken  in  1  actual outcome
- fb_ready  out  1  queue can accept feedback
- pht_en  out  1  RAM access enable
- pht_we  out  1  RAM write enable
- pht_addr  out  INDEX_WIDTH  RAM address
- pht_wdata  out  2  RAM write data
- pht_rdata  in  2  RAM read data, valid the cycle after a read

Behaviour:
- Index = pc[INDEX_WIDTH+1:2].
- Reset (rst sampled high):
  - FSM→INIT; init pointer=0; queue empty; starve count=0.
  - pred_valid=0, init_done=0, req_ready=0, fb_ready=0.
  - Any in-flight update is dropped; no write is issued in the cycle after rst.
- INIT:
  - Writes 2'b10 (weakly taken) to addresses 0..2^INDEX_WIDTH-1, one per cycle.
  - After the last write: →IDLE, init_done=1 (held until the next reset).
  - req_ready=0 and fb_ready=0 throughout INIT.
- Feedback enqueue:
  - Enqueue when fb_valid && fb_ready.
  - fb_ready = init_done && !full. There is no pop→push bypass when full.
  - An enqueued entry is visible to arbitration from the next cycle.
- Arbitration (in IDLE, i.e. port free):
  - If queue non-empty and (full, or starve count ≥ STARVE_LIMIT, or !req_valid): pop head, →UPD_RD.
  - Else if req_valid: req_ready=1 (combinational), issue read pht_en=1, pht_we=0, pht_addr=index(req_pc); stay IDLE.
- Prediction output: in the cycle after a grant, pred_valid=1 and pred_taken=pht_rdata[1]. Otherwise pred_valid=0.
- Starve count:
  - Increments, saturating, on each request grant while the queue is non-empty.
  - Clears to 0 on entry to UPD_RD.
- UPD_RD (1 cycle): read at the popped index; req_ready=0. →UPD_WR.
- UPD_WR (1 cycle): write pht_wdata = fb_taken ? min(rdata+1,3) : max(rdata-1,0); req_ready=0. →IDLE.
- An update therefore occupies the port for exactly 2 cycles.
- The queue holds {index, taken} and is FIFO-ordered.
- Predictions read table state as of their read cycle. Queued, not-yet-applied updates are not forwarded.
- pht_en=0 whenever no access is issued.

Test Plan:
- Reset, INDEX_WIDTH=6 → 64 consecutive writes, addr 0..63, wdata=2. init_done rises the cycle after addr 63 is written. req_ready/fb_ready stay 0 during INIT.
- After init, req_pc=0x10 → same cycle req_ready=1, pht_addr=4, pht_we=0. Next cycle pred_valid=1, pred_taken=1.
- Feedback pc=0x10 taken ×2, no requests:
  - First update: addr 4 read 2 → write 3.
  - Second update: read 3 → write 3 (saturation).
  - Then not-taken ×4 → writes 2,1,0,0. A subsequent request predicts 0.
- req_valid held high, one feedback enqueued:
  - Exactly 8 grants, then req_ready=0 for 2 cycles (UPD_RD, UPD_WR).
  - Grants resume; starve count reads 0.
- req_valid held high, 4 feedbacks on consecutive cycles:
  - fb_ready=0 after the 4th.
  - Update starts next arbitration despite starve count <8.
  - fb_ready returns to 1 the cycle after the pop.
- rst asserted during UPD_RD:
  - No write is issued the next cycle; queue empty.
  - INIT restarts at addr 0; pred_valid=0.
